uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  UART 8n1 receiver: the receive half paired with the TX-only uart_ctrl.
//  - Oversamples the async rx line 8x in the system clock domain.
//  - Recovers bytes LSB-first and presents each byte to the core on a valid/ready handshake.
//  - Buffers one byte; reports framing errors and overruns as 1-cycle pulses.
// PARAMETERS
//  CLK_DIV  54  clk cycles per oversample tick (bit time = 8*CLK_DIV clk); >=2
// PORTS
//  clk        in   1  system clock; single clock domain for the whole block
//  rst        in   1  synchronous reset, active-high
//  uart_rx    in   1  asynchronous serial input, idle high
//  valid      out  1  received byte available on data
//  ready      in   1  consumer accepts byte when valid&&ready
//  data       out  8  received byte; stable while valid
//  frame_err  out  1  1-cycle pulse: stop bit sampled 0, byte dropped
//  overrun    out  1  1-cycle pulse: byte completed while buffer full, new byte dropped
// BEHAVIOUR
//  - Reset: valid=0, data=0, frame_err=0, overrun=0, state=IDLE, synchronizer regs=1, counters=0.
//    Reset mid-frame aborts the frame; nothing is delivered.
//  - Sync: uart_rx -> 2 flops -> rx_s. Every decision uses rx_s only.
//  - Prescaler: pre counts 0..CLK_DIV-1; tick=1 when pre==CLK_DIV-1.
//  - Counters: smp (3b) counts ticks within a bit; bit_cnt (3b) counts data bits.
//  - IDLE: rx_s==0 -> pre=0, smp=0, go START.
//  - START: at tick with smp==3 (mid-bit), rx_s==1 -> false start, go IDLE.
//    At tick with smp==7 -> smp=0, bit_cnt=0, go DATA.
//  - DATA: at tick with smp==3, shift rx_s into shreg MSB (shreg>>1; LSB-first frame).
//    At tick with smp==7: bit_cnt==7 -> go STOP, else bit_cnt++.
//  - STOP: at tick with smp==3, sample rx_s:
//    rx_s==1 -> byte complete, go IDLE (next start edge caught from the second half of the stop bit).
//    rx_s==0 -> frame_err pulse next cycle, byte dropped, go BREAK.
//  - BREAK: wait for rx_s==1, then go IDLE. Prevents a low line from being taken as a new start.
//  - smp increments on every tick in START/DATA/STOP and wraps 7->0.
//  - Output buffer (one entry):
//    - On byte complete with valid==0: data<=shreg, valid<=1 the following cycle.
//    - valid&&ready: valid<=0 next cycle, unless a byte completes in the same cycle; then data<=new byte and valid stays 1 (no overrun).
//    - Byte complete with valid==1 and ready==0: overrun pulse; data/valid unchanged.
//  - Latency: valid rises 1 clk after the mid-stop sample, ~(9*8+4)*CLK_DIV+3 clk after the uart_rx falling edge.
//  - data holds its value after handshake until the next delivered byte.
//  - frame_err and overrun are never asserted simultaneously; each is exactly 1 clk wide.
// TESTING (CLK_DIV=4, bit=32 clk, ideal line model)
//  1. ready=1, send 0xA5 -> valid high 1 cycle, data=0xA5, frame_err=0, overrun=0.
//  2. ready=0, send 0x3C then 0x81 -> valid held with data=0x3C throughout, overrun pulses once at 0x81 stop;
//     then ready=1 -> valid drops next cycle.
//  3. rx low for 8 clk then high (glitch < half bit), then send 0x55 -> no valid for the glitch; 0x55 delivered.
//  4. send 0xFF with stop bit 0, hold low 3 bit times, then idle, send 0x00 -> frame_err pulses once, no valid;
//     0x00 delivered after the line returns high.
//  5. assert rst for 1 cycle mid-DATA of 0x12, resend 0x12 -> no valid from the aborted frame; second 0x12 delivered.
//  6. back-to-back 0x01,0xFE (no idle gap), ready=1 -> both delivered in order.
//     Repeat with ready asserted exactly in the completion cycle of 0xFE -> no overrun, data=0xFE.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART 8n1 receiver with 8x oversampling and a one-byte output buffer.
// The async rx line is synchronized, and the bits are sampled at mid-bit. Each byte is
// received LSB-first and handed to the core over a valid/ready handshake.
// Framing errors and overruns are reported as single-cycle pulses.
//
// Ports:
//   clk        system clock (single domain)
//   rst        synchronous reset, active-high
//   uart_rx    asynchronous serial input, idle high
//   valid      received byte available on data
//   ready      consumer accepts byte when valid && ready
//   data       received byte; stable while valid, held after handshake
//   frame_err  1-cycle pulse: stop bit sampled low, byte dropped
//   overrun    1-cycle pulse: byte completed while buffer full, new byte dropped
module uart_rx_ctrl #(
    parameter int unsigned CLK_DIV = 54
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       valid,
    input  logic       ready,
    output logic [7:0] data,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    state_t           state;
    logic             rx_m;
    logic             rx_s;
    logic [PRE_W-1:0] pre;
    logic [2:0]       smp;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;

    logic tick_c;
    logic mid_c;
    logic end_c;
    logic done_c;
    logic ferr_c;

    // Oversample strobe, mid-bit and end-of-bit points within the current bit.
    assign tick_c = (pre == PRE_W'(CLK_DIV - 1));
    assign mid_c  = tick_c && (smp == 3'd3);
    assign end_c  = tick_c && (smp == 3'd7);
    assign done_c = (state == STOP) && mid_c && rx_s;
    assign ferr_c = (state == STOP) && mid_c && !rx_s;

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= uart_rx;
            rx_s <= rx_m;
        end
    end

    // Prescaler; realigned on the start edge so ticks are phased to the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
        end else if ((state == IDLE) && !rx_s) begin
            pre <= '0;
        end else if (tick_c) begin
            pre <= '0;
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

    // Receive state machine with sample and bit counters and the shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            smp     <= 3'd0;
            bit_cnt <= 3'd0;
            shreg   <= 8'd0;
        end else begin
            if (tick_c && (state inside {START, DATA, STOP})) begin
                smp <= smp + 3'd1;
            end
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        smp   <= 3'd0;
                        state <= START;
                    end
                end
                START: begin
                    // A line that is high again at mid start bit was a glitch.
                    if (mid_c && rx_s) begin
                        state <= IDLE;
                    end else if (end_c) begin
                        bit_cnt <= 3'd0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (mid_c) begin
                        shreg <= {rx_s, shreg[7:1]};
                    end
                    if (end_c) begin
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                STOP: begin
                    // Leave at mid stop bit so the next start edge is not missed.
                    if (mid_c) begin
                        state <= rx_s ? IDLE : BRK;
                    end
                end
                BRK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One-entry output buffer with error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= 1'b0;
            data      <= 8'd0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_c;
            overrun   <= 1'b0;
            if (done_c) begin
                // A byte arriving in the handshake cycle refills the buffer.
                if (!valid || ready) begin
                    data  <= shreg;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl. An ideal line driver schedules, for each frame, the clock edge at
// which the receiver must finish that frame. A buffer model applies those completions to
// compute valid, data, frame_err and overrun for every cycle.
module tb_uart_rx_ctrl;

    localparam int unsigned CD  = 4;
    localparam int unsigned BIT = 8 * CD;
    // Frame completion edge relative to the edge before the start bit is driven:
    // 1 edge to reach the line, 2 synchronizer stages, then 9.5 bits minus half a tick-period path.
    localparam int LAT = 3 + 76 * CD;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic       valid;
    logic       ready;
    logic [7:0] data;
    logic       frame_err;
    logic       overrun;

    uart_rx_ctrl #(.CLK_DIV(CD)) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .valid     (valid),
        .ready     (ready),
        .data      (data),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int         e;
        logic [7:0] b;
        bit         ferr;
    } ev_t;

    ev_t        sched[$];
    logic [7:0] hs_q[$];
    int         edge_n;
    bit         m_valid;
    logic [7:0] m_data;
    bit         m_fe;
    bit         m_ov;
    int         n_vec;
    int         n_err;
    bit         chk_en;
    int         rdy_mode;
    int         pulse_edge;
    int         n_ovr;
    int         n_fe;
    int         rise_edge;
    bit         prev_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", name, edge_n, act, exp);
        end
    endtask

    function automatic logic [31:0] hs_at(input int i);
        if (i < hs_q.size()) return 32'(hs_q[i]);
        return 32'hFFFF_FFFF;
    endfunction

    // Cycle comparison of DUT against model plus observation bookkeeping.
    task automatic compare();
        if (chk_en) begin
            check("valid", 32'(valid), 32'(m_valid));
            check("data", 32'(data), 32'(m_data));
            check("frame_err", 32'(frame_err), 32'(m_fe));
            check("overrun", 32'(overrun), 32'(m_ov));
            check("err_excl", 32'(frame_err & overrun), 32'd0);
            if (valid === 1'b1 && ready === 1'b1) hs_q.push_back(data);
            if (overrun === 1'b1) n_ovr++;
            if (frame_err === 1'b1) n_fe++;
            if (valid === 1'b1 && !prev_valid) rise_edge = edge_n;
            prev_valid = (valid === 1'b1);
        end
    endtask

    // Buffer model: completions come from the line schedule.
    task automatic model_step();
        ev_t        ev;
        bit         done;
        logic [7:0] b;
        done = 1'b0;
        b    = 8'd0;
        edge_n++;
        if (rst) begin
            m_valid = 1'b0;
            m_data  = 8'd0;
            m_fe    = 1'b0;
            m_ov    = 1'b0;
            sched.delete();
        end else begin
            m_fe = 1'b0;
            m_ov = 1'b0;
            while (sched.size() > 0 && sched[0].e < edge_n) void'(sched.pop_front());
            if (sched.size() > 0 && sched[0].e == edge_n) begin
                ev = sched.pop_front();
                if (ev.ferr) m_fe = 1'b1;
                else begin
                    done = 1'b1;
                    b    = ev.b;
                end
            end
            if (done) begin
                if (!m_valid || ready) begin
                    m_data  = b;
                    m_valid = 1'b1;
                end else begin
                    m_ov = 1'b1;
                end
            end else if (m_valid && ready) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_step();
        #1;
        case (rdy_mode)
            1: ready = 1'($urandom_range(0, 1));
            2: ready = ($urandom_range(0, 15) == 0);
            3: ready = (edge_n + 1 == pulse_edge);
            default: ;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Ideal 8n1 line; a low stop bit may be stretched by tail extra bit times.
    task automatic send_frame(input logic [7:0] b, input bit stop, input int tail);
        ev_t ev;
        ev.e    = edge_n + LAT;
        ev.b    = b;
        ev.ferr = !stop;
        sched.push_back(ev);
        uart_rx = 1'b0;
        idle(BIT);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            idle(BIT);
        end
        uart_rx = stop;
        idle(stop ? BIT : BIT * (1 + tail));
        uart_rx = 1'b1;
    endtask

    initial begin
        int s;
        int c2;
        rst        = 1'b1;
        uart_rx    = 1'b1;
        ready      = 1'b0;
        rdy_mode   = 0;
        pulse_edge = -1;
        edge_n     = 0;
        n_vec      = 0;
        n_err      = 0;
        chk_en     = 1'b0;
        n_ovr      = 0;
        n_fe       = 0;
        rise_edge  = -1;
        prev_valid = 1'b0;
        m_valid    = 1'b0;
        m_data     = 8'd0;
        m_fe       = 1'b0;
        m_ov       = 1'b0;

        idle(3);
        chk_en = 1'b1;
        idle(1);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        rst = 1'b0;
        idle(BIT);

        // 1: single byte with ready high.
        ready = 1'b1;
        rise_edge = -1;
        s = edge_n;
        send_frame(8'hA5, 1'b1, 0);
        idle(BIT);
        check("t1_latency", 32'(rise_edge - s), 32'd307);
        check("t1_count", 32'(hs_q.size()), 32'd1);
        check("t1_byte", hs_at(0), 32'h0000_00A5);
        check("t1_errs", 32'(n_fe + n_ovr), 32'd0);
        hs_q.delete();

        // 2: overrun while the consumer stalls.
        ready = 1'b0;
        n_ovr = 0;
        send_frame(8'h3C, 1'b1, 0);
        send_frame(8'h81, 1'b1, 0);
        idle(BIT);
        check("t2_data_held", 32'(data), 32'h0000_003C);
        check("t2_ovr_count", 32'(n_ovr), 32'd1);
        ready = 1'b1;
        idle(2);
        check("t2_valid_drop", 32'(valid), 32'd0);
        check("t2_byte", hs_at(0), 32'h0000_003C);
        check("t2_count", 32'(hs_q.size()), 32'd1);
        hs_q.delete();

        // 3: short glitch is rejected, next byte is received.
        uart_rx = 1'b0;
        idle(8);
        uart_rx = 1'b1;
        idle(2 * BIT);
        check("t3_glitch", 32'(hs_q.size()), 32'd0);
        send_frame(8'h55, 1'b1, 0);
        idle(BIT);
        check("t3_byte", hs_at(0), 32'h0000_0055);
        check("t3_count", 32'(hs_q.size()), 32'd1);
        hs_q.delete();

        // 4: framing error followed by a held-low line, then recovery.
        n_fe = 0;
        send_frame(8'hFF, 1'b0, 3);
        idle(BIT);
        check("t4_fe_count", 32'(n_fe), 32'd1);
        check("t4_no_byte", 32'(hs_q.size()), 32'd0);
        send_frame(8'h00, 1'b1, 0);
        idle(BIT);
        check("t4_byte", hs_at(0), 32'h0000_0000);
        check("t4_count", 32'(hs_q.size()), 32'd1);
        hs_q.delete();

        // 5: reset in the middle of the data bits aborts the frame.
        uart_rx = 1'b0;
        idle(BIT);
        for (int i = 0; i < 4; i++) begin
            uart_rx = s[0] ^ s[0] ^ ((8'h12 >> i) & 8'h01) != 0;
            idle(BIT);
        end
        idle(BIT / 2);
        rst     = 1'b1;
        uart_rx = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(2 * BIT);
        check("t5_abort_valid", 32'(valid), 32'd0);
        check("t5_abort_count", 32'(hs_q.size()), 32'd0);
        send_frame(8'h12, 1'b1, 0);
        idle(BIT);
        check("t5_byte", hs_at(0), 32'h0000_0012);
        hs_q.delete();

        // 6a: back-to-back frames with ready high.
        ready = 1'b1;
        send_frame(8'h01, 1'b1, 0);
        send_frame(8'hFE, 1'b1, 0);
        idle(BIT);
        check("t6a_first", hs_at(0), 32'h0000_0001);
        check("t6a_second", hs_at(1), 32'h0000_00FE);
        hs_q.delete();

        // 6b: ready rises exactly in the completion cycle of the second byte.
        ready = 1'b0;
        n_ovr = 0;
        send_frame(8'h01, 1'b1, 0);
        c2         = edge_n + LAT;
        pulse_edge = c2;
        rdy_mode   = 3;
        send_frame(8'hFE, 1'b1, 0);
        rdy_mode = 0;
        ready    = 1'b0;
        idle(2);
        check("t6b_data", 32'(data), 32'h0000_00FE);
        check("t6b_valid", 32'(valid), 32'd1);
        check("t6b_no_ovr", 32'(n_ovr), 32'd0);
        check("t6b_first", hs_at(0), 32'h0000_0001);
        ready = 1'b1;
        idle(4);
        check("t6b_second", hs_at(1), 32'h0000_00FE);
        hs_q.delete();

        // Random frames, gaps and stop errors under two consumer behaviours.
        for (int mode = 1; mode <= 2; mode++) begin
            rdy_mode = mode;
            for (int k = 0; k < 20; k++) begin
                logic [7:0] b;
                bit         bad;
                int         tail;
                b    = 8'($urandom);
                bad  = ($urandom_range(0, 7) == 0);
                tail = bad ? int'($urandom_range(0, 2)) : 0;
                send_frame(b, !bad, tail);
                idle(int'($urandom_range(bad ? 1 : 0, 2)) * BIT + int'($urandom_range(0, 5)));
            end
        end

        rdy_mode = 0;
        ready    = 1'b1;
        idle(2 * BIT);
        check("sched_drained", 32'(sched.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
